// File: rtl/idex_pipe_reg_if.sv
// Bundle of decode-side inputs, hazard controls and execute-side outputs of the ID/EX register.
// The master side is decode plus the hazard unit; the slave side is the pipeline register.
interface idex_pipe_reg_if #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 4,
  parameter int PERF_W    = 32
);
  logic                 FlushE;
  logic                 StallE;
  logic                 PerfClr;

  logic                 ValidD;
  logic                 RegWriteD;
  logic                 MemWriteD;
  logic                 MemReadD;
  logic                 JumpD;
  logic                 BranchD;
  logic                 ALUSrcD;
  logic [1:0]           ResultSrcD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic [XLEN-1:0]      RD1D;
  logic [XLEN-1:0]      RD2D;
  logic [XLEN-1:0]      ImmExtD;
  logic [XLEN-1:0]      PCD;
  logic [XLEN-1:0]      PCPlus4D;
  logic [REG_AW-1:0]    Rs1D;
  logic [REG_AW-1:0]    Rs2D;
  logic [REG_AW-1:0]    RdD;

  logic                 ValidE;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic                 MemReadE;
  logic                 JumpE;
  logic                 BranchE;
  logic                 ALUSrcE;
  logic [1:0]           ResultSrcE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [XLEN-1:0]      RD1E;
  logic [XLEN-1:0]      RD2E;
  logic [XLEN-1:0]      ImmExtE;
  logic [XLEN-1:0]      PCE;
  logic [XLEN-1:0]      PCPlus4E;
  logic [REG_AW-1:0]    Rs1E;
  logic [REG_AW-1:0]    Rs2E;
  logic [REG_AW-1:0]    RdE;

  logic [PERF_W-1:0]    BubbleCount;
  logic [PERF_W-1:0]    StallCount;

  modport master (
    output FlushE, StallE, PerfClr,
    output ValidD, RegWriteD, MemWriteD, MemReadD, JumpD, BranchD, ALUSrcD,
    output ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
    output Rs1D, Rs2D, RdD,
    input  ValidE, RegWriteE, MemWriteE, MemReadE, JumpE, BranchE, ALUSrcE,
    input  ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    input  Rs1E, Rs2E, RdE,
    input  BubbleCount, StallCount
  );

  modport slave (
    input  FlushE, StallE, PerfClr,
    input  ValidD, RegWriteD, MemWriteD, MemReadD, JumpD, BranchD, ALUSrcD,
    input  ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
    input  Rs1D, Rs2D, RdD,
    output ValidE, RegWriteE, MemWriteE, MemReadE, JumpE, BranchE, ALUSrcE,
    output ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    output Rs1E, Rs2E, RdE,
    output BubbleCount, StallCount
  );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with flush (bubble) and stall (hold) control from the hazard unit.
// Define IDEX_PERF_EN to build the saturating bubble/stall performance counters.
module idex_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 4,
  parameter int PERF_W    = 32
) (
  input logic          clk,
  input logic          rst,
  idex_pipe_reg_if.slave bus
);

  // A flush zeroes every field so the hazard unit sees no register match against a bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushE) begin
      bus.ValidE      <= 1'b0;
      bus.RegWriteE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.MemReadE    <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.ALUControlE <= {ALUCTRL_W{1'b0}};
      bus.RD1E        <= {XLEN{1'b0}};
      bus.RD2E        <= {XLEN{1'b0}};
      bus.ImmExtE     <= {XLEN{1'b0}};
      bus.PCE         <= {XLEN{1'b0}};
      bus.PCPlus4E    <= {XLEN{1'b0}};
      bus.Rs1E        <= {REG_AW{1'b0}};
      bus.Rs2E        <= {REG_AW{1'b0}};
      bus.RdE         <= {REG_AW{1'b0}};
    end else if (!bus.StallE) begin
      // An invalid decode slot must not cause any architectural side effect downstream.
      bus.ValidE      <= bus.ValidD;
      bus.RegWriteE   <= bus.RegWriteD & bus.ValidD;
      bus.MemWriteE   <= bus.MemWriteD & bus.ValidD;
      bus.MemReadE    <= bus.MemReadD  & bus.ValidD;
      bus.JumpE       <= bus.JumpD     & bus.ValidD;
      bus.BranchE     <= bus.BranchD   & bus.ValidD;
      bus.ALUSrcE     <= bus.ALUSrcD;
      bus.ResultSrcE  <= bus.ResultSrcD;
      bus.ALUControlE <= bus.ALUControlD;
      bus.RD1E        <= bus.RD1D;
      bus.RD2E        <= bus.RD2D;
      bus.ImmExtE     <= bus.ImmExtD;
      bus.PCE         <= bus.PCD;
      bus.PCPlus4E    <= bus.PCPlus4D;
      bus.Rs1E        <= bus.Rs1D;
      bus.Rs2E        <= bus.Rs2D;
      bus.RdE         <= bus.RdD;
    end
  end

`ifdef IDEX_PERF_EN
  logic [PERF_W-1:0] bubble_count;
  logic [PERF_W-1:0] stall_count;

  // Counters stick at all-ones rather than wrapping so a long run never reads as small.
  always_ff @(posedge clk) begin
    if (rst || bus.PerfClr) begin
      bubble_count <= {PERF_W{1'b0}};
      stall_count  <= {PERF_W{1'b0}};
    end else begin
      if (bus.FlushE && (bubble_count != {PERF_W{1'b1}})) begin
        bubble_count <= bubble_count + 1'b1;
      end
      if (bus.StallE && !bus.FlushE && (stall_count != {PERF_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  assign bus.BubbleCount = bubble_count;
  assign bus.StallCount  = stall_count;
`else
  logic unused_perf_clr;

  assign unused_perf_clr = bus.PerfClr;
  assign bus.BubbleCount = {PERF_W{1'b0}};
  assign bus.StallCount  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
// [TB] Self-checking bench for idex_pipe_reg: directed scenarios plus randomized traffic against a stage model.
// A second instance with PERF_W = 2 exercises counter saturation.
module tb_idex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic        memread;
    logic        jump;
    logic        branch;
    logic        alusrc;
    logic [1:0]  resultsrc;
    logic [3:0]  aluctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } stage_t;

`ifdef IDEX_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst;
  logic   flush;
  logic   stall;
  logic   perf_clr;
  stage_t din;
  stage_t exp_e;
  stage_t o;

  longint bub_m, stl_m, bub2_m, stl2_m;
  int     checks = 0;
  int     failures = 0;

  idex_pipe_reg_if #(.XLEN(32), .REG_AW(5), .ALUCTRL_W(4), .PERF_W(32)) bus ();
  idex_pipe_reg_if #(.XLEN(32), .REG_AW(5), .ALUCTRL_W(4), .PERF_W(2))  bus2 ();

  idex_pipe_reg #(.XLEN(32), .REG_AW(5), .ALUCTRL_W(4), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  idex_pipe_reg #(.XLEN(32), .REG_AW(5), .ALUCTRL_W(4), .PERF_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.FlushE       = flush;
    bus.StallE       = stall;
    bus.PerfClr      = perf_clr;
    bus.ValidD       = din.valid;
    bus.RegWriteD    = din.regwrite;
    bus.MemWriteD    = din.memwrite;
    bus.MemReadD     = din.memread;
    bus.JumpD        = din.jump;
    bus.BranchD      = din.branch;
    bus.ALUSrcD      = din.alusrc;
    bus.ResultSrcD   = din.resultsrc;
    bus.ALUControlD  = din.aluctrl;
    bus.RD1D         = din.rd1;
    bus.RD2D         = din.rd2;
    bus.ImmExtD      = din.imm;
    bus.PCD          = din.pc;
    bus.PCPlus4D     = din.pcplus4;
    bus.Rs1D         = din.rs1;
    bus.Rs2D         = din.rs2;
    bus.RdD          = din.rd;
    bus2.FlushE      = flush;
    bus2.StallE      = stall;
    bus2.PerfClr     = perf_clr;
    bus2.ValidD      = din.valid;
    bus2.RegWriteD   = din.regwrite;
    bus2.MemWriteD   = din.memwrite;
    bus2.MemReadD    = din.memread;
    bus2.JumpD       = din.jump;
    bus2.BranchD     = din.branch;
    bus2.ALUSrcD     = din.alusrc;
    bus2.ResultSrcD  = din.resultsrc;
    bus2.ALUControlD = din.aluctrl;
    bus2.RD1D        = din.rd1;
    bus2.RD2D        = din.rd2;
    bus2.ImmExtD     = din.imm;
    bus2.PCD         = din.pc;
    bus2.PCPlus4D    = din.pcplus4;
    bus2.Rs1D        = din.rs1;
    bus2.Rs2D        = din.rs2;
    bus2.RdD         = din.rd;
  end

  function automatic stage_t obs_e();
    stage_t s;
    s.valid     = bus.ValidE;
    s.regwrite  = bus.RegWriteE;
    s.memwrite  = bus.MemWriteE;
    s.memread   = bus.MemReadE;
    s.jump      = bus.JumpE;
    s.branch    = bus.BranchE;
    s.alusrc    = bus.ALUSrcE;
    s.resultsrc = bus.ResultSrcE;
    s.aluctrl   = bus.ALUControlE;
    s.rd1       = bus.RD1E;
    s.rd2       = bus.RD2E;
    s.imm       = bus.ImmExtE;
    s.pc        = bus.PCE;
    s.pcplus4   = bus.PCPlus4E;
    s.rs1       = bus.Rs1E;
    s.rs2       = bus.Rs2E;
    s.rd        = bus.RdE;
    return s;
  endfunction

  function automatic stage_t rand_stage();
    stage_t s;
    s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return s;
  endfunction

  // Behavioural view: reset/flush give an empty slot, stall keeps the old one, otherwise the
  // decoded instruction moves over, with side-effect controls dropped for an invalid slot.
  function automatic stage_t model_next(stage_t cur, stage_t d, logic r, logic f, logic s);
    stage_t n;
    if (r || f) begin
      n = '0;
    end else if (s) begin
      n = cur;
    end else begin
      n = d;
      if (!d.valid) begin
        n.regwrite = 1'b0;
        n.memwrite = 1'b0;
        n.memread  = 1'b0;
        n.jump     = 1'b0;
        n.branch   = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic longint sat_inc(longint v, longint maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic tick();
    exp_e = model_next(exp_e, din, rst, flush, stall);
    if (rst || perf_clr) begin
      bub_m = 0; stl_m = 0; bub2_m = 0; stl2_m = 0;
    end else if (flush) begin
      bub_m  = sat_inc(bub_m, 64'hFFFF_FFFF);
      bub2_m = sat_inc(bub2_m, 3);
    end else if (stall) begin
      stl_m  = sat_inc(stl_m, 64'hFFFF_FFFF);
      stl2_m = sat_inc(stl2_m, 3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; perf_clr = 1'b0;
    din = rand_stage();
    din.valid = 1'b1; din.regwrite = 1'b1; din.rd = 5'd5; din.rd1 = 32'hDEADBEEF;
    tick();
    tick();
    o = obs_e();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=0", o);
    end
    checks++;
    if ({bus.BubbleCount, bus.StallCount, bus2.BubbleCount, bus2.StallCount} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_counters got=%0d/%0d/%0d/%0d want=0", bus.BubbleCount,
               bus.StallCount, bus2.BubbleCount, bus2.StallCount);
    end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    din = rand_stage();
    din.valid = 1'b1; din.regwrite = 1'b1; din.rd = 5'd5; din.rs1 = 5'd3;
    din.rd1 = 32'h0000_1234; din.pc = 32'h100;
    tick();
    o = obs_e();
    checks++;
    if ({o.valid, o.regwrite, o.rd, o.rs1, o.rd1, o.pc} !==
        {1'b1, 1'b1, 5'd5, 5'd3, 32'h0000_1234, 32'h100}) begin
      failures++;
      $display("[TB] FAIL capture_fields got v=%b rw=%b rd=%0d rs1=%0d rd1=%h pc=%h",
               o.valid, o.regwrite, o.rd, o.rs1, o.rd1, o.pc);
    end
    checks++;
    if (o !== din) begin
      failures++;
      $display("[TB] FAIL capture_all got=%h want=%h", o, din);
    end
  endtask

  task automatic test_invalid_capture();
    din = rand_stage();
    din.valid = 1'b0; din.regwrite = 1'b1; din.memwrite = 1'b1; din.memread = 1'b1;
    din.jump = 1'b1; din.branch = 1'b1; din.alusrc = 1'b1; din.rd = 5'd17;
    tick();
    o = obs_e();
    checks++;
    if ({o.valid, o.regwrite, o.memwrite, o.memread, o.jump, o.branch, o.alusrc, o.rd, o.rd1} !==
        {7'b0000001, 5'd17, din.rd1}) begin
      failures++;
      $display("[TB] FAIL invalid_capture got=%h want=%h", o, exp_e);
    end
    din = rand_stage();
    din.valid = 1'b1; din.regwrite = 1'b1; din.rd = 5'd0;
    tick();
    o = obs_e();
    checks++;
    if ({o.valid, o.regwrite, o.rd} !== {1'b1, 1'b1, 5'd0}) begin
      failures++;
      $display("[TB] FAIL x0_passthrough got v=%b rw=%b rd=%0d want 1 1 0", o.valid, o.regwrite, o.rd);
    end
  endtask

  task automatic test_load_use_bubble();
    din = rand_stage();
    din.valid = 1'b1; din.memread = 1'b1; din.regwrite = 1'b1; din.rd = 5'd7;
    flush = 1'b1;
    tick();
    o = obs_e();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("[TB] FAIL bubble_zero got=%h want=0", o);
    end
    flush = 1'b0;
    tick();
    o = obs_e();
    checks++;
    if ({o.memread, o.rd, o.valid} !== {1'b1, 5'd7, 1'b1}) begin
      failures++;
      $display("[TB] FAIL after_bubble got mr=%b rd=%0d v=%b want 1 7 1", o.memread, o.rd, o.valid);
    end
  endtask

  task automatic test_stall();
    stage_t a;
    a = rand_stage();
    a.valid = 1'b1; a.rd = 5'd9;
    din = a;
    tick();
    o = obs_e();
    checks++;
    if (o.rd !== 5'd9) begin
      failures++;
      $display("[TB] FAIL stall_load_a got rd=%0d want 9", o.rd);
    end
    din = rand_stage();
    din.valid = 1'b1; din.rd = 5'd12;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = obs_e();
      checks++;
      if (o !== a) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d got=%h want=%h", i, o, a);
      end
    end
    stall = 1'b0;
    tick();
    o = obs_e();
    checks++;
    if ((o.rd !== 5'd12) || (o !== din)) begin
      failures++;
      $display("[TB] FAIL stall_release got rd=%0d want 12", o.rd);
    end
  endtask

  task automatic test_flush_over_stall();
    din = rand_stage();
    din.valid = 1'b1; din.rd = 5'd21;
    tick();
    flush = 1'b1; stall = 1'b1;
    din = rand_stage();
    tick();
    o = obs_e();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("[TB] FAIL flush_over_stall got=%h want=0", o);
    end
    flush = 1'b0; stall = 1'b0;
    din.valid = 1'b1; din.rd = 5'd30;
    tick();
    o = obs_e();
    checks++;
    if ((o.rd !== 5'd30) || (o.valid !== 1'b1)) begin
      failures++;
      $display("[TB] FAIL capture_after_flush got rd=%0d v=%b want 30 1", o.rd, o.valid);
    end
  endtask

  task automatic test_perf();
    longint want_b, want_s;
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    flush = 1'b1;
    repeat (3) tick();
    flush = 1'b0; stall = 1'b1;
    repeat (2) tick();
    stall = 1'b0;
    want_b = PERF_EN ? 3 : 0;
    want_s = PERF_EN ? 2 : 0;
    checks++;
    if ((longint'(bus.BubbleCount) != want_b) || (longint'(bus.StallCount) != want_s)) begin
      failures++;
      $display("[TB] FAIL perf_counts got b=%0d s=%0d want b=%0d s=%0d",
               bus.BubbleCount, bus.StallCount, want_b, want_s);
    end
    perf_clr = 1'b1; flush = 1'b1;
    tick();
    checks++;
    if ({bus.BubbleCount, bus.StallCount} !== '0) begin
      failures++;
      $display("[TB] FAIL perf_clear got b=%0d s=%0d want 0 0", bus.BubbleCount, bus.StallCount);
    end
    perf_clr = 1'b0;
    repeat (5) tick();
    flush = 1'b0;
    checks++;
    if ((longint'(bus2.BubbleCount) != (PERF_EN ? 3 : 0)) ||
        (longint'(bus.BubbleCount) != (PERF_EN ? 5 : 0))) begin
      failures++;
      $display("[TB] FAIL perf_saturate got narrow=%0d wide=%0d", bus2.BubbleCount, bus.BubbleCount);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      din      = rand_stage();
      flush    = ($urandom_range(0, 99) < 15);
      stall    = ($urandom_range(0, 99) < 25);
      perf_clr = ($urandom_range(0, 99) < 3);
      rst      = ($urandom_range(0, 99) < 2);
      tick();
      o = obs_e();
      checks++;
      if (o !== exp_e) begin
        failures++;
        $display("[TB] FAIL random_stage_%0d got=%h want=%h", i, o, exp_e);
      end
      checks++;
      if ((longint'(bus.BubbleCount)  != (PERF_EN ? bub_m  : 0)) ||
          (longint'(bus.StallCount)   != (PERF_EN ? stl_m  : 0)) ||
          (longint'(bus2.BubbleCount) != (PERF_EN ? bub2_m : 0)) ||
          (longint'(bus2.StallCount)  != (PERF_EN ? stl2_m : 0))) begin
        failures++;
        $display("[TB] FAIL random_perf_%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i,
                 bus.BubbleCount, bus.StallCount, bus2.BubbleCount, bus2.StallCount,
                 bub_m, stl_m, bub2_m, stl2_m);
      end
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0; perf_clr = 1'b0;
  endtask

  initial begin
    exp_e = '0;
    bub_m = 0; stl_m = 0; bub2_m = 0; stl2_m = 0;
    test_reset();
    test_capture();
    test_invalid_capture();
    test_load_use_bubble();
    test_stall();
    test_flush_over_stall();
    test_perf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
